// File: rtl/game_pkg.sv
// Shared game types: lane encoding and the obstacle scheduler state set.
package game_pkg;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE_LEFT   = 2'd0;
    localparam lane_t LANE_CENTRE = 2'd1;
    localparam lane_t LANE_RIGHT  = 2'd2;

    typedef enum logic [1:0] {IDLE, GAP, PICK, ISSUE} sched_state_t;

    // Rotate to the next legal lane, wrapping right back to left.
    function automatic lane_t next_lane(input lane_t l);
        return (l == LANE_RIGHT) ? LANE_LEFT : lane_t'(l + 2'd1);
    endfunction

endpackage

// File: rtl/game_lfsr.sv
// 16-bit right-shifting Galois LFSR with seed reload, shared by randomised game blocks.
module game_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] MASK = 16'hB400
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_advance,
    input  logic        i_load,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= SEED;
        end else if (i_advance) begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? MASK : '0);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: counts game ticks between spawns, picks a lane/type
// from an LFSR and offers each spawn to the obstacle store over valid/ready.
module obstacle_scheduler
    import game_pkg::*;
#(
    parameter int unsigned BASE_GAP    = 16,
    parameter int unsigned MIN_GAP     = 4,
    parameter int unsigned SPEED_SHIFT = 6,
    parameter int unsigned MAX_LEVEL   = 7,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        playing,
    input  logic        reset_game,
    input  logic        pulse,
    input  logic [11:0] time_alive,
    input  logic        spawn_ready,
    output logic        spawn_valid,
    output logic [1:0]  spawn_lane,
    output logic        spawn_jumpable,
    output logic [2:0]  speed_level,
    output logic [7:0]  spawn_count
);

    sched_state_t r_state, w_state_n;
    logic [7:0]   r_gap, w_gap_n;
    logic         r_valid, w_valid_n;
    lane_t        r_lane, w_lane_n;
    logic         r_jump, w_jump_n;
    lane_t        r_prev_lane, w_prev_lane_n;
    logic         r_prev_block, w_prev_block_n;
    logic [7:0]   r_count, w_count_n;
    logic [2:0]   r_speed;

    logic [15:0]  w_lfsr;
    logic         w_unused_lfsr;
    logic [11:0]  w_shifted;
    logic [2:0]   w_speed_n;
    logic [7:0]   w_dec;
    logic [7:0]   w_cur_gap;
    lane_t        w_pick_lane;
    logic         w_pick_jump;

    game_lfsr #(
        .SEED(LFSR_SEED),
        .MASK(16'hB400)
    ) u_lfsr (
        .i_clk    (clk_in),
        .i_rst_n  (rst_in),
        .i_advance(1'b1),
        .i_load   (reset_game),
        .o_lfsr   (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:3];

    assign w_shifted = time_alive >> SPEED_SHIFT;
    assign w_speed_n = (w_shifted > 12'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : w_shifted[2:0];

    // Compare before subtracting so the 8-bit gap never wraps below MIN_GAP.
    assign w_dec     = {4'd0, r_speed, 1'b0};
    assign w_cur_gap = (8'(BASE_GAP) >= 8'(MIN_GAP) + w_dec) ? 8'(BASE_GAP) - w_dec : 8'(MIN_GAP);

    assign w_pick_lane = (w_lfsr[1:0] == 2'd3) ? next_lane(r_prev_lane) : w_lfsr[1:0];
    // Never stack two full blocks in the same lane.
    assign w_pick_jump = w_lfsr[2] | (r_prev_block & (w_pick_lane == r_prev_lane));

    always_comb begin
        w_state_n      = r_state;
        w_gap_n        = r_gap;
        w_valid_n      = r_valid;
        w_lane_n       = r_lane;
        w_jump_n       = r_jump;
        w_prev_lane_n  = r_prev_lane;
        w_prev_block_n = r_prev_block;
        w_count_n      = r_count;
        case (r_state)
            IDLE: begin
                if (playing) begin
                    w_gap_n   = w_cur_gap;
                    w_state_n = GAP;
                end
            end
            GAP: begin
                if (!playing) begin
                    w_state_n = IDLE;
                end else if (pulse) begin
                    w_gap_n = r_gap - 8'd1;
                    if (r_gap == 8'd1) w_state_n = PICK;
                end
            end
            PICK: begin
                if (!playing) begin
                    w_state_n = IDLE;
                end else begin
                    w_lane_n  = w_pick_lane;
                    w_jump_n  = w_pick_jump;
                    w_valid_n = 1'b1;
                    w_state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (spawn_ready) begin
                    w_valid_n      = 1'b0;
                    w_count_n      = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                    w_prev_lane_n  = r_lane;
                    w_prev_block_n = ~r_jump;
                    w_gap_n        = w_cur_gap;
                    w_state_n      = GAP;
                end else if (!playing) begin
                    w_valid_n = 1'b0;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state      <= IDLE;
            r_gap        <= '0;
            r_valid      <= 1'b0;
            r_lane       <= LANE_LEFT;
            r_jump       <= 1'b0;
            r_prev_lane  <= LANE_LEFT;
            r_prev_block <= 1'b0;
            r_count      <= '0;
            r_speed      <= '0;
        end else if (reset_game) begin
            r_state      <= IDLE;
            r_gap        <= '0;
            r_valid      <= 1'b0;
            r_lane       <= LANE_LEFT;
            r_jump       <= 1'b0;
            r_prev_lane  <= LANE_LEFT;
            r_prev_block <= 1'b0;
            r_count      <= '0;
            r_speed      <= '0;
        end else begin
            r_state      <= w_state_n;
            r_gap        <= w_gap_n;
            r_valid      <= w_valid_n;
            r_lane       <= w_lane_n;
            r_jump       <= w_jump_n;
            r_prev_lane  <= w_prev_lane_n;
            r_prev_block <= w_prev_block_n;
            r_count      <= w_count_n;
            if (playing) r_speed <= w_speed_n;
        end
    end

    assign spawn_valid    = r_valid;
    assign spawn_lane     = r_lane;
    assign spawn_jumpable = r_jump;
    assign speed_level    = r_speed;
    assign spawn_count    = r_count;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed self-checking bench for obstacle_scheduler.
module tb_obstacle_scheduler;
    import game_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        playing = 1'b0;
    logic        reset_game = 1'b0;
    logic        pulse = 1'b0;
    logic [11:0] time_alive = '0;
    logic        spawn_ready = 1'b0;
    logic        spawn_valid;
    logic [1:0]  spawn_lane;
    logic        spawn_jumpable;
    logic [2:0]  speed_level;
    logic [7:0]  spawn_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_count = 0;

    obstacle_scheduler #(
        .BASE_GAP(16),
        .MIN_GAP(4),
        .SPEED_SHIFT(6),
        .MAX_LEVEL(7),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .playing       (playing),
        .reset_game    (reset_game),
        .pulse         (pulse),
        .time_alive    (time_alive),
        .spawn_ready   (spawn_ready),
        .spawn_valid   (spawn_valid),
        .spawn_lane    (spawn_lane),
        .spawn_jumpable(spawn_jumpable),
        .speed_level   (speed_level),
        .spawn_count   (spawn_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, want finish before 1000000");
        $fatal(1);
    end

    task automatic tick(input logic p);
        @(negedge clk_in);
        pulse = p;
    endtask

    // Drives a pulse every 'per' cycles until spawn_valid is seen.
    task automatic run_until_spawn(input int per, input int max_cyc, output int npulse,
                                   output int lat, output logic [1:0] lane,
                                   output logic jump, output logic ok);
        int   last_p;
        logic p;
        last_p = -100;
        npulse = 0;
        lat    = -1;
        lane   = '0;
        jump   = 1'b0;
        ok     = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            p = ((i % per) == 0);
            tick(p);
            if (spawn_valid === 1'b1) begin
                lat   = i - last_p;
                lane  = spawn_lane;
                jump  = spawn_jumpable;
                ok    = 1'b1;
                pulse = 1'b0;
                break;
            end
            if (p) begin
                npulse++;
                last_p = i;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_in = 1'b0;
        tick(0);
        tick(0);
        n_cmp++;
        if ({spawn_valid, spawn_lane, spawn_jumpable, speed_level, spawn_count} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {spawn_valid, spawn_lane, spawn_jumpable, speed_level, spawn_count});
        end
        n_cmp++;
        if (dut.u_lfsr.o_lfsr !== 16'hACE1) begin
            n_err++;
            $display("FAIL reset_lfsr: got %h want ace1", dut.u_lfsr.o_lfsr);
        end
        rst_in = 1'b1;
        tick(0);
        n_cmp++;
        if (dut.u_lfsr.o_lfsr !== 16'hE270) begin
            n_err++;
            $display("FAIL lfsr_step1: got %h want e270", dut.u_lfsr.o_lfsr);
        end
    endtask

    task automatic test_idle();
        logic seen;
        seen = 1'b0;
        playing = 1'b0;
        time_alive = 12'd4095;
        for (int i = 0; i < 400; i++) begin
            tick((i % 4) == 0);
            if (spawn_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL idle_valid: got %b want 0", seen);
        end
        n_cmp++;
        if (speed_level !== 3'd0 || spawn_count !== 8'd0) begin
            n_err++;
            $display("FAIL idle_hold: got speed %0d count %0d want 0 0", speed_level, spawn_count);
        end
        time_alive = 12'd0;
    endtask

    task automatic test_first_spawn();
        int np, lat;
        logic [1:0] ln;
        logic jp, ok;
        spawn_ready = 1'b1;
        playing = 1'b1;
        tick(0);
        run_until_spawn(4, 200, np, lat, ln, jp, ok);
        n_cmp++;
        if (ok !== 1'b1 || np !== 16 || lat !== 2) begin
            n_err++;
            $display("FAIL first_timing: got ok %b pulses %0d lat %0d want 1 16 2", ok, np, lat);
        end
        n_cmp++;
        if (ln === 2'd3) begin
            n_err++;
            $display("FAIL first_lane: got %0d want 0..2", ln);
        end
        tick(0);
        exp_count = 1;
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'(exp_count)) begin
            n_err++;
            $display("FAIL first_accept: got valid %b count %0d want 0 %0d", spawn_valid, spawn_count, exp_count);
        end
    endtask

    task automatic test_backpressure();
        int np, lat;
        logic [1:0] ln;
        logic jp, ok, stable;
        spawn_ready = 1'b0;
        run_until_spawn(4, 200, np, lat, ln, jp, ok);
        n_cmp++;
        if (ok !== 1'b1 || np !== 16) begin
            n_err++;
            $display("FAIL bp_gap: got ok %b pulses %0d want 1 16", ok, np);
        end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick((i % 4) == 0);
            if (spawn_valid !== 1'b1 || spawn_lane !== ln || spawn_jumpable !== jp ||
                spawn_count !== 8'(exp_count)) stable = 1'b0;
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_err++;
            $display("FAIL bp_stable: got %b want 1", stable);
        end
        spawn_ready = 1'b1;
        tick(0);
        exp_count++;
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'(exp_count)) begin
            n_err++;
            $display("FAIL bp_accept: got valid %b count %0d want 0 %0d", spawn_valid, spawn_count, exp_count);
        end
        tick(0);
        tick(0);
        n_cmp++;
        if (spawn_count !== 8'(exp_count)) begin
            n_err++;
            $display("FAIL bp_single: got %0d want %0d", spawn_count, exp_count);
        end
        run_until_spawn(4, 200, np, lat, ln, jp, ok);
        n_cmp++;
        if (ok !== 1'b1 || np !== 16) begin
            n_err++;
            $display("FAIL bp_next_gap: got ok %b pulses %0d want 1 16", ok, np);
        end
        tick(0);
        exp_count++;
    endtask

    task automatic test_ramp();
        int np, lat;
        logic [1:0] ln;
        logic jp, ok;
        int exp_gap [4] = '{16, 10, 10, 4};
        time_alive = 12'd192;
        tick(0);
        n_cmp++;
        if (speed_level !== 3'd3) begin
            n_err++;
            $display("FAIL ramp_lvl3: got %0d want 3", speed_level);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                time_alive = 12'd4095;
                tick(0);
                n_cmp++;
                if (speed_level !== 3'd7) begin
                    n_err++;
                    $display("FAIL ramp_lvl7: got %0d want 7", speed_level);
                end
            end
            run_until_spawn(4, 200, np, lat, ln, jp, ok);
            n_cmp++;
            if (ok !== 1'b1 || np !== exp_gap[k]) begin
                n_err++;
                $display("FAIL ramp_gap%0d: got ok %b pulses %0d want 1 %0d", k, ok, np, exp_gap[k]);
            end
            tick(0);
            exp_count++;
        end
        n_cmp++;
        if (spawn_count !== 8'(exp_count)) begin
            n_err++;
            $display("FAIL ramp_count: got %0d want %0d", spawn_count, exp_count);
        end
        time_alive = 12'd0;
    endtask

    task automatic test_reset_game_issue();
        int np, lat;
        logic [1:0] ln;
        logic jp, ok;
        spawn_ready = 1'b0;
        run_until_spawn(4, 200, np, lat, ln, jp, ok);
        reset_game = 1'b1;
        spawn_ready = 1'b1;
        tick(1);
        exp_count = 0;
        n_cmp++;
        if (ok !== 1'b1 || spawn_valid !== 1'b0 || spawn_count !== 8'd0 || speed_level !== 3'd0) begin
            n_err++;
            $display("FAIL rg_clear: got ok %b valid %b count %0d speed %0d want 1 0 0 0",
                     ok, spawn_valid, spawn_count, speed_level);
        end
        n_cmp++;
        if (dut.r_state !== IDLE || dut.u_lfsr.o_lfsr !== 16'hACE1) begin
            n_err++;
            $display("FAIL rg_state_lfsr: got state %0d lfsr %h want 0 ace1", dut.r_state, dut.u_lfsr.o_lfsr);
        end
        reset_game = 1'b0;
        tick(0);
        n_cmp++;
        if (dut.u_lfsr.o_lfsr !== 16'hE270) begin
            n_err++;
            $display("FAIL rg_lfsr_step: got %h want e270", dut.u_lfsr.o_lfsr);
        end
    endtask

    task automatic replay_seq(output logic [5:0] lanes, output logic [2:0] jumps, output logic all_ok);
        int np, lat;
        logic [1:0] ln;
        logic jp, ok;
        all_ok = 1'b1;
        lanes = '0;
        jumps = '0;
        reset_game = 1'b1;
        playing = 1'b1;
        spawn_ready = 1'b1;
        time_alive = 12'd0;
        tick(0);
        reset_game = 1'b0;
        tick(0);
        for (int k = 0; k < 3; k++) begin
            run_until_spawn(4, 200, np, lat, ln, jp, ok);
            if (ok !== 1'b1 || ln === 2'd3) all_ok = 1'b0;
            lanes[2*k +: 2] = ln;
            jumps[k] = jp;
            tick(0);
        end
    endtask

    task automatic test_replay();
        logic [5:0] l_a, l_b;
        logic [2:0] j_a, j_b;
        logic ok_a, ok_b;
        replay_seq(l_a, j_a, ok_a);
        replay_seq(l_b, j_b, ok_b);
        n_cmp++;
        if (ok_a !== 1'b1 || ok_b !== 1'b1) begin
            n_err++;
            $display("FAIL replay_ok: got %b %b want 1 1", ok_a, ok_b);
        end
        n_cmp++;
        if ({l_b, j_b} !== {l_a, j_a}) begin
            n_err++;
            $display("FAIL replay_seq: got %h want %h", {l_b, j_b}, {l_a, j_a});
        end
        exp_count = 3;
    endtask

    task automatic test_fairness();
        int np, lat;
        logic [1:0] ln;
        logic jp, ok;
        logic [15:0] forced [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0003};
        logic [1:0]  want_l [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd0};
        logic        want_j [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        reset_game = 1'b1;
        playing = 1'b1;
        spawn_ready = 1'b1;
        tick(0);
        reset_game = 1'b0;
        exp_count = 0;
        for (int k = 0; k < 5; k++) begin
            force dut.u_lfsr.r_lfsr = forced[k];
            run_until_spawn(4, 200, np, lat, ln, jp, ok);
            n_cmp++;
            if (ok !== 1'b1 || ln !== want_l[k] || jp !== want_j[k]) begin
                n_err++;
                $display("FAIL fair_pick%0d: got ok %b lane %0d jump %b want 1 %0d %b",
                         k, ok, ln, jp, want_l[k], want_j[k]);
            end
            tick(0);
            exp_count++;
        end
        release dut.u_lfsr.r_lfsr;
        n_cmp++;
        if (spawn_count !== 8'(exp_count)) begin
            n_err++;
            $display("FAIL fair_count: got %0d want %0d", spawn_count, exp_count);
        end
    endtask

    task automatic test_abort();
        int np, lat;
        logic [1:0] ln;
        logic jp, ok;
        spawn_ready = 1'b0;
        run_until_spawn(4, 200, np, lat, ln, jp, ok);
        playing = 1'b0;
        tick(0);
        n_cmp++;
        if (ok !== 1'b1 || spawn_valid !== 1'b0 || spawn_count !== 8'(exp_count) || dut.r_state !== IDLE) begin
            n_err++;
            $display("FAIL abort: got ok %b valid %b count %0d state %0d want 1 0 %0d 0",
                     ok, spawn_valid, spawn_count, dut.r_state, exp_count);
        end
        spawn_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick((i % 4) == 0);
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'(exp_count)) begin
            n_err++;
            $display("FAIL abort_idle: got valid %b count %0d want 0 %0d", spawn_valid, spawn_count, exp_count);
        end
    endtask

    task automatic test_saturate();
        int np, lat;
        logic [1:0] ln;
        logic jp, ok;
        logic all_ok;
        logic [7:0] at255;
        all_ok = 1'b1;
        at255 = '0;
        reset_game = 1'b1;
        time_alive = 12'd4095;
        playing = 1'b1;
        spawn_ready = 1'b1;
        tick(0);
        reset_game = 1'b0;
        for (int k = 0; k < 260; k++) begin
            run_until_spawn(1, 100, np, lat, ln, jp, ok);
            if (ok !== 1'b1) all_ok = 1'b0;
            tick(0);
            if (k == 254) at255 = spawn_count;
        end
        n_cmp++;
        if (all_ok !== 1'b1 || at255 !== 8'd255 || spawn_count !== 8'd255) begin
            n_err++;
            $display("FAIL saturate: got ok %b at255 %0d final %0d want 1 255 255", all_ok, at255, spawn_count);
        end
        playing = 1'b0;
        time_alive = 12'd0;
        tick(0);
        tick(0);
        n_cmp++;
        if (speed_level !== 3'd7 || spawn_count !== 8'd255) begin
            n_err++;
            $display("FAIL hold_stopped: got speed %0d count %0d want 7 255", speed_level, spawn_count);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_first_spawn();
        test_backpressure();
        test_ramp();
        test_reset_game_issue();
        test_replay();
        test_fairness();
        test_abort();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
